mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the core's single data-memory port between the instruction fetch unit (IFU) and the load/store path driven by the decoder's dmem_req/dmem_wen controls (LSU). It accepts one request at a time via valid/ready handshakes and forwards it to memory. It captures the memory response and returns it to the owning requester. Round-robin arbitration prevents either requester from starving the other. It sits between the IF/EX-MEM stages and the memory bus model.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between IFU and LSU.
// One transaction in flight, round-robin grant on ties.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_wen,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE, REQ, RESP, DONE
   } state_t;

   state_t state;
   state_t next;

   logic              owner;
   logic              last_grant;
   logic              wen_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [DATA_W-1:0] rdata_buf;

   logic grant_ifu;
   logic grant_lsu;
   logic accept;
   logic owner_ack;

   // Tie goes to whoever was not granted last.
   always_comb begin
      grant_ifu = ifu_req_valid & (~lsu_req_valid | last_grant);
      grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant);
      accept    = (state == IDLE) & ~rst & (grant_ifu | grant_lsu);
      owner_ack = owner ? lsu_resp_ready : ifu_resp_ready;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   // Next-state logic.
   always_comb begin
      next = state;
      unique case (state)
         IDLE: if (accept)         next = REQ;
         REQ:  if (mem_req_ready)  next = RESP;
         RESP: if (mem_resp_valid) next = DONE;
         DONE: if (owner_ack)      next = IDLE;
         default:                  next = IDLE;
      endcase
   end

   // Latch the winning request and the memory response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_buf  <= '0;
      end else begin
         if (accept) begin
            owner      <= grant_lsu;
            last_grant <= grant_lsu;
            if (grant_lsu) begin
               wen_q   <= lsu_wen;
               addr_q  <= lsu_addr;
               wdata_q <= lsu_wdata;
               wstrb_q <= lsu_wstrb;
            end else begin
               wen_q   <= 1'b0;
               addr_q  <= ifu_addr;
               wdata_q <= '0;
               wstrb_q <= '0;
            end
         end
         if (state == RESP && mem_resp_valid)
            rdata_buf <= mem_rdata;
      end
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      ifu_req_ready  = accept & grant_ifu;
      lsu_req_ready  = accept & grant_lsu;
      mem_req_valid  = (state == REQ);
      mem_resp_ready = (state == RESP);
      ifu_resp_valid = (state == DONE) & ~owner;
      lsu_resp_valid = (state == DONE) & owner;
      mem_wen        = wen_q;
      mem_addr       = addr_q;
      mem_wdata      = wdata_q;
      mem_wstrb      = wstrb_q;
      ifu_rdata      = rdata_buf;
      lsu_rdata      = rdata_buf;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter
// against a transaction-level reference model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [3:0]  lsu_wstrb;
   logic        lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_rdata;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_rdata;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: one pending transaction and what it waits for.
   // wait_for: 1 = memory to take it, 2 = memory data, 3 = consumer.
   bit          busy;
   int          wait_for;
   bit          m_own;
   bit          m_last;
   bit          m_wen;
   logic [31:0] m_addr, m_wdata, m_buf;
   logic [3:0]  m_wstrb;

   int          cyc = 0;
   int          g_cyc, r_cyc, r_count = 0;
   bit          r_who;
   logic [31:0] r_data;
   bit          g_q[$];

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      busy = 0; wait_for = 0; m_own = 0; m_last = 1;
      m_wen = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_buf = 0;
   endtask

   task automatic check_update();
      bit gi, gl;
      if (rst) model_reset();
      gi = !rst && !busy && ifu_req_valid && (!lsu_req_valid || m_last);
      gl = !rst && !busy && lsu_req_valid && (!ifu_req_valid || !m_last);
      check("ifu_req_ready", ifu_req_ready, gi);
      check("lsu_req_ready", lsu_req_ready, gl);
      check("mem_req_valid", mem_req_valid, busy && wait_for == 1);
      check("mem_resp_ready", mem_resp_ready, busy && wait_for == 2);
      check("ifu_resp_valid", ifu_resp_valid,
            busy && wait_for == 3 && !m_own);
      check("lsu_resp_valid", lsu_resp_valid,
            busy && wait_for == 3 && m_own);
      if (rst || (busy && wait_for == 1)) begin
         check("mem_wen", mem_wen, m_wen);
         check("mem_addr", mem_addr, m_addr);
         check("mem_wdata", mem_wdata, m_wdata);
         check("mem_wstrb", mem_wstrb, m_wstrb);
      end
      if (rst) check("rst_rdata", ifu_rdata, 0);
      if (busy && wait_for == 3) begin
         check("resp_rdata", m_own ? lsu_rdata : ifu_rdata, m_buf);
         r_cyc = cyc; r_who = m_own; r_count++;
         r_data = m_own ? lsu_rdata : ifu_rdata;
      end
      if (!rst) begin
         if (gi || gl) begin
            busy = 1; wait_for = 1; m_own = gl; m_last = gl;
            m_wen   = gl ? lsu_wen : 1'b0;
            m_addr  = gl ? lsu_addr : ifu_addr;
            m_wdata = gl ? lsu_wdata : 32'h0;
            m_wstrb = gl ? lsu_wstrb : 4'h0;
            g_cyc = cyc; g_q.push_back(gl);
         end else if (busy) begin
            if (wait_for == 1 && mem_req_ready) wait_for = 2;
            else if (wait_for == 2 && mem_resp_valid) begin
               m_buf = mem_rdata; wait_for = 3;
            end else if (wait_for == 3 &&
                         (m_own ? lsu_resp_ready : ifu_resp_ready))
               busy = 0;
         end
      end
      cyc++;
   endtask

   task automatic step();
      #1;
      check_update();
      @(negedge clk);
   endtask

   task automatic idle_in();
      ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
      lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0;
      lsu_wdata = 0; lsu_wstrb = 0; lsu_resp_ready = 1;
      mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 0;
   endtask

   int rc;

   initial begin
      model_reset();
      idle_in();
      ifu_req_valid = 1; lsu_req_valid = 1;
      rst = 1;
      @(negedge clk);
      step();
      rst = 0;
      idle_in();

      // IFU-only read: response three cycles after accept.
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
      mem_rdata = 32'h0000_0413;
      step();
      ifu_req_valid = 0;
      repeat (4) step();
      check("ifu_lat", r_cyc - g_cyc, 3);
      check("ifu_rdata", r_data, 32'h0000_0413);
      check("ifu_owner", r_who, 0);

      // LSU store with partial strobe.
      lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
      mem_req_ready = 0;
      step();
      lsu_req_valid = 0;
      #1;
      check("st_wen", mem_wen, 1);
      check("st_wstrb", mem_wstrb, 4'b0011);
      check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_addr", mem_addr, 32'h8000_1000);
      step();
      mem_req_ready = 1;
      repeat (4) step();
      check("st_ack_owner", r_who, 1);

      // Both requesting: alternating grants.
      idle_in();
      ifu_req_valid = 1; ifu_addr = 32'h0000_0100;
      lsu_req_valid = 1; lsu_addr = 32'h0000_0200;
      g_q.delete();
      repeat (16) step();
      check("rr_count", g_q.size(), 4);
      if (g_q.size() >= 4) begin
         check("rr_0", g_q[0], 0);
         check("rr_1", g_q[1], 1);
         check("rr_2", g_q[2], 0);
         check("rr_3", g_q[3], 1);
      end

      // Back-pressure on request and response.
      idle_in();
      lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
      lsu_wdata = 32'h55AA_55AA;
      mem_req_ready = 0; mem_resp_valid = 0;
      step();
      lsu_req_valid = 0; ifu_req_valid = 1;
      ifu_addr = 32'h8000_0010;
      repeat (5) begin
         #1;
         check("bp_addr", mem_addr, 32'h8000_2000);
         check("bp_wdata", mem_wdata, 32'h55AA_55AA);
         check("bp_no_grant", ifu_req_ready, 0);
         step();
      end
      mem_req_ready = 1; mem_resp_valid = 1;
      mem_rdata = 32'hCAFE_F00D; lsu_resp_ready = 0;
      step();
      step();
      mem_rdata = 32'h0BAD_0BAD;
      repeat (3) begin
         #1;
         check("bp_rvalid", lsu_resp_valid, 1);
         check("bp_rdata", lsu_rdata, 32'hCAFE_F00D);
         check("bp_no_grant2", ifu_req_ready, 0);
         step();
      end
      lsu_resp_ready = 1;
      step();
      step();
      ifu_req_valid = 0;
      repeat (4) step();

      // Asynchronous reset while in REQ.
      idle_in();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
      mem_req_ready = 0;
      step();
      ifu_req_valid = 0;
      step();
      #1;
      check("pre_rst_req", mem_req_valid, 1);
      rst = 1;
      #1;
      check("rst_drop", mem_req_valid, 0);
      step();
      rst = 0;
      mem_req_ready = 1;
      rc = r_count;
      repeat (5) step();
      check("rst_noresp", r_count - rc, 0);
      ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
      mem_rdata = 32'h0010_0073;
      step();
      ifu_req_valid = 0;
      repeat (4) step();
      check("post_rst_lat", r_cyc - g_cyc, 3);
      check("post_rst_data", r_data, 32'h0010_0073);

      // Stray memory response while idle.
      idle_in();
      mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
      rc = r_count;
      repeat (3) step();
      #1;
      check("stray_ready", mem_resp_ready, 0);
      check("stray_buf", ifu_rdata, 32'h0010_0073);
      check("stray_noresp", r_count - rc, 0);
      step();

      // Random traffic against the model.
      repeat (1500) begin
         rst            = ($urandom_range(0, 199) == 0);
         ifu_req_valid  = $urandom_range(0, 1) == 1;
         ifu_addr       = $urandom;
         ifu_resp_ready = $urandom_range(0, 3) != 0;
         lsu_req_valid  = $urandom_range(0, 1) == 1;
         lsu_wen        = $urandom_range(0, 1) == 1;
         lsu_addr       = $urandom;
         lsu_wdata      = $urandom;
         lsu_wstrb      = 4'($urandom);
         lsu_resp_ready = $urandom_range(0, 3) != 0;
         mem_req_ready  = $urandom_range(0, 2) != 0;
         mem_resp_valid = $urandom_range(0, 2) != 0;
         mem_rdata      = $urandom;
         step();
      end
      rst = 0;
      idle_in();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
